// File: rtl/dram_responder_pkg.sv
// Shared bus definitions for the DRAM responder: widths, HSIZE codes, FSM states.
package dram_responder_pkg;

  localparam int unsigned DataWidth = 64;
  localparam int unsigned AddrWidth = 64;

  typedef enum logic [1:0] {
    SizeByte  = 2'd0,
    SizeHalf  = 2'd1,
    SizeWord  = 2'd2,
    SizeDword = 2'd3
  } hsize_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] mask;
    unique case (hsize_e'(size))
      SizeByte:  mask = 3'b000;
      SizeHalf:  mask = 3'b001;
      SizeWord:  mask = 3'b011;
      SizeDword: mask = 3'b111;
      default:   mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dram_byte_merge.sv
// Combinational byte-lane merge of lane-aligned write data into a stored word.
module dram_byte_merge
  import dram_responder_pkg::*;
(
  input  logic [DataWidth-1:0] old_word,
  input  logic [DataWidth-1:0] wdata,
  input  logic [1:0]           size,
  input  logic [2:0]           offset,
  output logic [DataWidth-1:0] merged
);

  logic [7:0] byte_mask;
  logic [3:0] first_lane;
  logic [3:0] end_lane;

  assign first_lane = {1'b0, offset};
  assign end_lane   = first_lane + (4'd1 << size);

  // Enable the 2^size lanes starting at the byte offset.
  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < 8; i++) begin
      byte_mask[i] = (4'(i) >= first_lane) && (4'(i) < end_lane);
    end
  end

  // Take enabled lanes from the write data, keep the rest of the old word.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 8; i++) begin
      if (byte_mask[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dram_responder.sv
// Single-outstanding DRAM-like responder with programmable wait states.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 HTRANS,
  input  logic [AddrWidth-1:0] HADDR,
  input  logic                 HWRITE,
  input  logic [1:0]           HSIZE,
  input  logic [DataWidth-1:0] HWDATA,
  output logic [DataWidth-1:0] HRDATA,
  output logic                 HREADY,
  output logic                 HRESP
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitLast = 4'(WAIT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AddrWidth-1:0] addr_q;
  logic                 write_q;
  logic [1:0]           size_q;
  logic [DataWidth-1:0] wdata_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 accept;
  logic                 enter_resp;

  logic [DataWidth-1:0] mem [DEPTH_WORDS];

  // With zero wait states the accepting edge is also the committing edge, so the
  // transfer fields come straight from the bus while idle.
  logic [AddrWidth-1:0] cur_addr;
  logic                 cur_write;
  logic [1:0]           cur_size;
  logic [DataWidth-1:0] cur_wdata;
  logic [IdxW-1:0]      cur_idx;
  logic                 cur_err;
  logic [DataWidth-1:0] merged;

  assign cur_addr  = (state_q == StIdle) ? HADDR  : addr_q;
  assign cur_write = (state_q == StIdle) ? HWRITE : write_q;
  assign cur_size  = (state_q == StIdle) ? HSIZE  : size_q;
  assign cur_wdata = (state_q == StIdle) ? HWDATA : wdata_q;
  assign cur_idx   = cur_addr[3 +: IdxW];
  assign cur_err   = (|cur_addr[AddrWidth-1:3+IdxW]) ||
                     (|(cur_addr[2:0] & align_mask(cur_size)));

  dram_byte_merge u_merge (
    .old_word (mem[cur_idx]),
    .wdata    (cur_wdata),
    .size     (cur_size),
    .offset   (cur_addr[2:0]),
    .merged   (merged)
  );

  // Next-state logic: accept in idle, count wait states, one-cycle response.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (HTRANS) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (WAIT_CYCLES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == WaitLast) begin
          state_d    = StResp;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counter and latched transfer fields.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        size_q  <= HSIZE;
        wdata_q <= HWDATA;
      end
    end
  end

  // Storage: commit legal writes and capture read data on the edge entering RESP.
  // RESET gates the write so an edge during reset cannot commit anything.
  always_ff @(posedge CLK) begin
    if (enter_resp && RESET && !cur_err) begin
      if (cur_write) mem[cur_idx] <= merged;
      else           rdata_q      <= mem[cur_idx];
    end
  end

  // Outputs are only non-zero during the single response cycle.
  always_comb begin
    HREADY = (state_q == StResp);
    HRESP  = HREADY && cur_err;
    HRDATA = (HREADY && !cur_err && !write_q) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_dram_responder.sv
// Directed testbench for dram_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_dram_responder;

  logic        clk;
  logic        rst_n;
  logic        htrans, hwrite;
  logic [63:0] haddr, hwdata, hrdata;
  logic [1:0]  hsize;
  logic        hready, hresp;

  logic        htrans0;
  logic [63:0] hrdata0;
  logic        hready0, hresp0;

  int checks = 0;
  int errors = 0;

  dram_responder #(.DEPTH_WORDS(512), .WAIT_CYCLES(2)) dut (
    .CLK(clk), .RESET(rst_n), .HTRANS(htrans), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp)
  );

  dram_responder #(.DEPTH_WORDS(512), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .RESET(rst_n), .HTRANS(htrans0), .HADDR(64'h0), .HWRITE(1'b1),
    .HSIZE(2'd3), .HWDATA(64'h0123_4567_89AB_CDEF), .HRDATA(hrdata0), .HREADY(hready0),
    .HRESP(hresp0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transfer on the WAIT_CYCLES=2 instance; lat counts cycles after the accept edge.
  task automatic xfer(input logic wr, input logic [1:0] sz, input logic [63:0] addr,
                      input logic [63:0] wd, output logic [63:0] rd, output logic rsp,
                      output int lat);
    @(negedge clk);
    htrans = 1'b1; hwrite = wr; hsize = sz; haddr = addr; hwdata = wd;
    @(posedge clk);
    @(negedge clk);
    htrans = 1'b0;
    lat = 1;
    while (!hready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd  = hrdata;
    rsp = hresp;
  endtask

  logic [63:0] rd;
  logic        rsp;
  int          lat;

  initial begin
    rst_n = 1'b0; htrans = 1'b0; hwrite = 1'b0; hsize = 2'd0; haddr = '0; hwdata = '0;
    htrans0 = 1'b0;
    #2;
    check("reset_hready", {63'd0, hready}, 64'd0);
    check("reset_hresp", {63'd0, hresp}, 64'd0);
    check("reset_hrdata", hrdata, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Dword write then read-back.
    xfer(1'b1, 2'd3, 64'h40, 64'h1122_3344_5566_7788, rd, rsp, lat);
    check("wr40_lat", 64'(lat), 64'd3);
    check("wr40_resp", {63'd0, rsp}, 64'd0);
    check("wr40_rdata", rd, 64'd0);
    xfer(1'b0, 2'd3, 64'h40, 64'h0, rd, rsp, lat);
    check("rd40_lat", 64'(lat), 64'd3);
    check("rd40_data", rd, 64'h1122_3344_5566_7788);
    check("rd40_resp", {63'd0, rsp}, 64'd0);

    // Byte merge at lane 3.
    xfer(1'b1, 2'd0, 64'h43, 64'h0000_0000_AA00_0000, rd, rsp, lat);
    check("wr43_resp", {63'd0, rsp}, 64'd0);
    xfer(1'b0, 2'd3, 64'h40, 64'h0, rd, rsp, lat);
    check("rd40_merged", rd, 64'h1122_3344_AA66_7788);

    // Misaligned half-word write leaves memory alone.
    xfer(1'b1, 2'd1, 64'h41, 64'hFFFF_FFFF_FFFF_FFFF, rd, rsp, lat);
    check("mis_resp", {63'd0, rsp}, 64'd1);
    check("mis_rdata", rd, 64'd0);
    xfer(1'b0, 2'd3, 64'h40, 64'h0, rd, rsp, lat);
    check("rd40_after_mis", rd, 64'h1122_3344_AA66_7788);

    // Out of range read.
    xfer(1'b0, 2'd3, 64'h1000, 64'h0, rd, rsp, lat);
    check("oor_resp", {63'd0, rsp}, 64'd1);
    check("oor_rdata", rd, 64'd0);

    // Legal word write at an aligned offset inside the word.
    xfer(1'b1, 2'd2, 64'h44, 64'h5A5A_5A5A_0000_0000, rd, rsp, lat);
    xfer(1'b0, 2'd3, 64'h40, 64'h0, rd, rsp, lat);
    check("rd40_word_hi", rd, 64'h5A5A_5A5A_AA66_7788);

    // Reset during WAIT aborts a write.
    xfer(1'b1, 2'd3, 64'h80, 64'hCAFE_F00D_1234_5678, rd, rsp, lat);
    @(negedge clk);
    htrans = 1'b1; hwrite = 1'b1; hsize = 2'd3; haddr = 64'h80;
    hwdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    htrans = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstwait_hready", {63'd0, hready}, 64'd0);
    check("rstwait_hrdata", hrdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstwait_no_resp", {63'd0, hready}, 64'd0);
    end
    xfer(1'b0, 2'd3, 64'h80, 64'h0, rd, rsp, lat);
    check("rd80_prior", rd, 64'hCAFE_F00D_1234_5678);

    // Reset during RESP clears outputs immediately.
    @(negedge clk);
    htrans = 1'b1; hwrite = 1'b0; hsize = 2'd3; haddr = 64'h80;
    @(posedge clk);
    @(negedge clk);
    htrans = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("resp_hready", {63'd0, hready}, 64'd1);
    check("resp_hrdata", hrdata, 64'hCAFE_F00D_1234_5678);
    #1 rst_n = 1'b0;
    #1;
    check("rstresp_hready", {63'd0, hready}, 64'd0);
    check("rstresp_hrdata", hrdata, 64'd0);
    check("rstresp_hresp", {63'd0, hresp}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WAIT_CYCLES=0: four back-to-back request cycles give two transfers.
    @(negedge clk);
    htrans0 = 1'b1;
    begin
      int n_xfer;
      logic [3:0] pat;
      n_xfer = 0;
      pat = '0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        pat[i] = hready0;
        if (hready0) n_xfer++;
      end
      htrans0 = 1'b0;
      @(negedge clk);
      if (hready0) n_xfer++;
      check("busy_pattern", {60'd0, pat}, 64'b0101);
      check("busy_count", 64'(n_xfer), 64'd2);
      check("busy_resp", {63'd0, hresp0}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 512, meaning number of 64-bit words stored; power of two, at least 2.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning added wait states per transfer; legal range 0..15.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port HTRANS  input  1  transfer request from the bus master or mem controller.
REQ-006 SHALL have port HADDR  input  64  byte address.
REQ-007 SHALL have port HWRITE  input  1  1 = write, 0 = read.
REQ-008 SHALL have port HSIZE  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-009 SHALL have port HWDATA  input  64  write data, lane-aligned to HADDR[2:0].
REQ-010 SHALL have port HRDATA  output  64  read data; full 64-bit word.
REQ-011 SHALL have port HREADY  output  1  one-cycle completion strobe.
REQ-012 SHALL have port HRESP  output  1  error flag; valid only while HREADY is 1.

Function
REQ-013 SHALL implement states IDLE, WAIT and RESP.
REQ-014 In IDLE with HTRANS=1 at a rising edge, SHALL latch HADDR, HWRITE, HSIZE and HWDATA, then go to WAIT; if WAIT_CYCLES=0, SHALL go directly to RESP.
REQ-015 In WAIT, a counter SHALL count WAIT_CYCLES edges, then go to RESP.
REQ-016 RESP SHALL last exactly one cycle, with HREADY=1, then return to IDLE.
REQ-017 HREADY SHALL first be high WAIT_CYCLES+1 cycles after the accepting edge; minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-018 HTRANS SHALL be ignored in WAIT and RESP; no queuing and no side effects.
REQ-019 Word index SHALL be latched HADDR[3+log2(DEPTH_WORDS)-1:3].
REQ-020 Out of range: if any HADDR bit above the word index is nonzero, the transfer SHALL be out of range.
REQ-021 Misaligned: if HADDR[2:0] is not a multiple of 2^HSIZE, the transfer SHALL be misaligned.
REQ-022 An out-of-range or misaligned transfer SHALL set HRESP=1 in RESP, drive HRDATA=0, and leave memory unmodified.
REQ-023 A legal write SHALL merge only the 2^HSIZE byte lanes starting at HADDR[2:0], leaving the other lanes unchanged.
REQ-024 A legal write SHALL commit on the edge entering RESP; HRDATA during a write response SHALL be 0.
REQ-025 A legal read SHALL drive the stored 64-bit word on HRDATA during RESP, ignoring HSIZE; lane extraction is the initiator's job.
REQ-026 A read issued right after a write to the same word SHALL return the merged data.
REQ-027 Outside RESP, HRDATA, HREADY and HRESP SHALL be 0.

Reset
REQ-028 RESET low SHALL immediately force state IDLE, counter 0, HREADY=0, HRESP=0 and HRDATA=0, regardless of CLK.
REQ-029 Reset during WAIT SHALL abort the transfer; a pending write SHALL NOT commit.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 The first request SHALL be accepted on the first rising edge after RESET deasserts, if HTRANS=1 at that edge.

Structure
REQ-032 A shared bus package SHALL hold the HSIZE encodings, the state encoding, and the data/address width constants (64).
REQ-033 SHALL contain one sub-module, dram_byte_merge: a combinational lane-mask and merge of old word, HWDATA, HSIZE and offset.
REQ-034 Storage SHALL be a plain register array, inferable as synchronous RAM, with no reset.

Verification
REQ-035 Write/read-back, WAIT_CYCLES=2: write dword 0x1122334455667788 to 0x40; read 0x40 -> HREADY exactly 3 cycles after accept, HRDATA 0x1122334455667788, HRESP 0.
REQ-036 Byte merge: on top of REQ-035, byte-write 0xAA to 0x43, then read 0x40 -> 0x11223344AA667788.
REQ-037 Misaligned: half-word write to 0x41 -> HRESP=1, HRDATA=0; a following read of 0x40 is unchanged.
REQ-038 Out of range, DEPTH_WORDS=512: read 0x1000 -> HRESP=1, HRDATA=0.
REQ-039 Reset mid-transfer: pull RESET low in WAIT of a write to 0x80 -> outputs 0 at once; a later read of 0x80 returns the prior contents.
REQ-040 Busy ignore, WAIT_CYCLES=0: HTRANS held high for 4 cycles -> exactly 2 transfers, HREADY high in cycles 2 and 4.
